// File: rtl/adjust_curve_if.sv
// Request/acknowledge pixel handshake used on both sides of adjust_curve.
// Ports (signals):
//   req   - request, driven by the master side
//   ack   - one-cycle acknowledge, driven by the slave side; pixel valid
//   pixel - WIDTH-bit pixel level, driven by the slave side
interface adjust_curve_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req;
    logic             ack;
    logic [WIDTH-1:0] pixel;

    modport master (output req, input ack, input pixel);
    modport slave  (input req, output ack, output pixel);
endinterface

// File: rtl/adjust_curve.sv
// Piecewise-linear tone curve for one pixel channel. Maps an input level
// through NKNOT programmable knots plus fixed endpoints (0,0) and (MAX,MAX),
// interpolating with a restoring divider (one quotient bit per cycle).
// Ports:
//   clk, xrst       - clock, synchronous active-high reset
//   rcv (master)    - upstream pixel fetch: req out, ack/pixel in
//   snd (slave)     - downstream delivery: req in, ack/pixel out (registered)
//   knot_x, knot_y  - knot k at [k*WIDTH +: WIDTH]
//   cfg_load        - request to copy knot_x/knot_y into shadow registers
module adjust_curve #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NKNOT = 2
) (
    input  logic                   clk,
    input  logic                   xrst,
    adjust_curve_if.master         rcv,
    adjust_curve_if.slave          snd,
    input  logic [NKNOT*WIDTH-1:0] knot_x,
    input  logic [NKNOT*WIDTH-1:0] knot_y,
    input  logic                   cfg_load
);
    localparam int unsigned CNT_MAX = (NKNOT > WIDTH) ? NKNOT : WIDTH;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned SEL_W   = $clog2(NKNOT + 1);
    localparam logic [WIDTH-1:0] MAXV = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SCAN,
        S_MUL,
        S_DIV,
        S_ACK
    } state_t;

    // Evenly spaced knots on the diagonal: identity mapping.
    function automatic logic [WIDTH-1:0] knot_default(input int unsigned k);
        return WIDTH'((64'(k) + 64'd1) * 64'(MAXV) / 64'(NKNOT + 1));
    endfunction

    state_t             state_q;
    logic               rcv_req_q;
    logic               snd_ack_q;
    logic               pend_q;
    logic               found_q;
    logic               byp_q;
    logic [WIDTH-1:0]   pixel_out_q;
    logic [WIDTH-1:0]   v_q;
    logic [WIDTH-1:0]   div_q;
    logic [WIDTH-1:0]   base_q;
    logic [WIDTH-1:0]   byp_val_q;
    logic [WIDTH-1:0]   kx_q [NKNOT];
    logic [WIDTH-1:0]   ky_q [NKNOT];
    logic [CNT_W-1:0]   cnt_q;
    logic [SEL_W-1:0]   sel_q;
    logic [2*WIDTH-1:0] acc_q;

    logic [WIDTH-1:0]   scan_x_c;
    logic [WIDTH-1:0]   x0_c;
    logic [WIDTH-1:0]   y0_c;
    logic [WIDTH-1:0]   x1_c;
    logic [WIDTH-1:0]   y1_c;
    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH:0]     trial_c;
    logic [WIDTH:0]     sum_c;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   res_d;

    // Point lookup: scan_x_c is the upper x of segment cnt_q, x0/x1/y0/y1
    // are the endpoints of the selected segment sel_q.
    always_comb begin : point_mux
        scan_x_c = MAXV;
        x0_c     = '0;
        y0_c     = '0;
        x1_c     = MAXV;
        y1_c     = MAXV;
        for (int unsigned k = 0; k < NKNOT; k++) begin
            if (cnt_q == CNT_W'(k)) scan_x_c = kx_q[k];
            if (sel_q == SEL_W'(k + 1)) begin
                x0_c = kx_q[k];
                y0_c = ky_q[k];
            end
            if (sel_q == SEL_W'(k)) begin
                x1_c = kx_q[k];
                y1_c = ky_q[k];
            end
        end
        prod_c = (2*WIDTH)'(v_q - x0_c) * (2*WIDTH)'(y1_c - y0_c);
    end

    // One restoring-division step. Upper half of acc is the partial
    // remainder, lower half shifts in quotient bits MSB first.
    always_comb begin : div_step
        trial_c = acc_q[2*WIDTH-1:WIDTH-1];
        if (trial_c >= {1'b0, div_q}) begin
            acc_d = {trial_c[WIDTH-1:0] - div_q, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {trial_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        sum_c = {1'b0, base_q} + {1'b0, acc_d[WIDTH-1:0]};
        res_d = sum_c[WIDTH] ? MAXV : sum_c[WIDTH-1:0];
    end

    // Control FSM, shadow knots and datapath registers.
    always_ff @(posedge clk) begin
        if (xrst) begin
            state_q     <= S_IDLE;
            rcv_req_q   <= 1'b0;
            snd_ack_q   <= 1'b0;
            pend_q      <= 1'b0;
            found_q     <= 1'b0;
            byp_q       <= 1'b0;
            pixel_out_q <= '0;
            v_q         <= '0;
            div_q       <= '0;
            base_q      <= '0;
            byp_val_q   <= '0;
            cnt_q       <= '0;
            sel_q       <= '0;
            acc_q       <= '0;
            for (int unsigned k = 0; k < NKNOT; k++) begin
                kx_q[k] <= knot_default(k);
                ky_q[k] <= knot_default(k);
            end
        end else begin
            pend_q <= pend_q | cfg_load;
            case (state_q)
                S_IDLE: begin
                    // Knots only change between pixels.
                    if (pend_q) begin
                        pend_q <= 1'b0;
                        for (int unsigned k = 0; k < NKNOT; k++) begin
                            kx_q[k] <= knot_x[k*WIDTH +: WIDTH];
                            ky_q[k] <= knot_y[k*WIDTH +: WIDTH];
                        end
                    end
                    if (snd.req) begin
                        state_q   <= S_REQ;
                        rcv_req_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (rcv.ack) begin
                        v_q       <= rcv.pixel;
                        rcv_req_q <= 1'b0;
                        cnt_q     <= '0;
                        sel_q     <= SEL_W'(NKNOT);
                        found_q   <= 1'b0;
                        state_q   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // First segment whose upper x covers v wins.
                    if (!found_q && (v_q <= scan_x_c)) begin
                        found_q <= 1'b1;
                        sel_q   <= SEL_W'(cnt_q);
                    end
                    if (cnt_q == CNT_W'(NKNOT)) begin
                        cnt_q   <= '0;
                        state_q <= S_MUL;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_MUL: begin
                    acc_q  <= prod_c;
                    div_q  <= x1_c - x0_c;
                    base_q <= y0_c;
                    // Vertical or misconfigured segments skip the quotient.
                    if (x1_c == x0_c) begin
                        byp_q     <= 1'b1;
                        byp_val_q <= y1_c;
                    end else if ((y1_c < y0_c) || (v_q < x0_c)) begin
                        byp_q     <= 1'b1;
                        byp_val_q <= y0_c;
                    end else begin
                        byp_q     <= 1'b0;
                        byp_val_q <= y0_c;
                    end
                    cnt_q   <= '0;
                    state_q <= S_DIV;
                end
                S_DIV: begin
                    acc_q <= acc_d;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        cnt_q       <= '0;
                        pixel_out_q <= byp_q ? byp_val_q : res_d;
                        snd_ack_q   <= 1'b1;
                        state_q     <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_ACK: begin
                    snd_ack_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rcv.req   = rcv_req_q;
    assign snd.ack   = snd_ack_q;
    assign snd.pixel = pixel_out_q;
endmodule

// File: tb/tb_adjust_curve.sv
// Self-checking bench for adjust_curve: directed knot sets plus randomized
// pixels/knots, checked every cycle against a segment-table reference model.
module tb_adjust_curve;
    localparam int WIDTH = 8;
    localparam int NKNOT = 2;
    localparam int LAT   = NKNOT + WIDTH + 3;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic                   clk = 1'b0;
    logic                   xrst;
    logic [NKNOT*WIDTH-1:0] knot_x;
    logic [NKNOT*WIDTH-1:0] knot_y;
    logic                   cfg_load;

    adjust_curve_if #(.WIDTH(WIDTH)) rcv_if ();
    adjust_curve_if #(.WIDTH(WIDTH)) snd_if ();

    adjust_curve #(.WIDTH(WIDTH), .NKNOT(NKNOT)) dut (
        .clk      (clk),
        .xrst     (xrst),
        .rcv      (rcv_if),
        .snd      (snd_if),
        .knot_x   (knot_x),
        .knot_y   (knot_y),
        .cfg_load (cfg_load)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int cyc;
        int val;
    } exp_t;
    exp_t expq[$];
    int   exp_out = 0;
    bit   chk_en  = 1'b0;
    int   mkx[NKNOT];
    int   mky[NKNOT];
    bit   mpend = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference: build the full point table and interpolate directly.
    function automatic int model_map(input int v);
        int px[NKNOT+2];
        int py[NKNOT+2];
        int s;
        bit hit;
        int x0, y0, x1, y1;
        longint q;
        px[0] = 0;
        py[0] = 0;
        px[NKNOT+1] = MAXV;
        py[NKNOT+1] = MAXV;
        for (int k = 0; k < NKNOT; k++) begin
            px[k+1] = mkx[k];
            py[k+1] = mky[k];
        end
        s   = NKNOT;
        hit = 1'b0;
        for (int i = 0; i <= NKNOT; i++) begin
            if (!hit && v <= px[i+1]) begin
                s   = i;
                hit = 1'b1;
            end
        end
        x0 = px[s];
        y0 = py[s];
        x1 = px[s+1];
        y1 = py[s+1];
        if (x1 == x0) return y1;
        if (y1 < y0 || v < x0) return y0;
        q = longint'(v - x0) * longint'(y1 - y0) / longint'(x1 - x0);
        q = q + y0;
        if (q > MAXV) q = MAXV;
        return int'(q);
    endfunction

    // Per-cycle compare: snd_ack only at scheduled cycles, pixel_out held.
    always @(negedge clk) begin
        if (chk_en) begin
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                chk("snd_ack_at_latency", longint'(snd_if.ack), 1);
                chk("pixel_out_at_ack", longint'(snd_if.pixel), expq[0].val);
                exp_out = expq[0].val;
                void'(expq.pop_front());
            end else begin
                chk("snd_ack_quiet", longint'(snd_if.ack), 0);
                chk("pixel_out_hold", longint'(snd_if.pixel), exp_out);
            end
        end
    end

    task automatic do_reset(input int hold);
        chk_en      = 1'b0;
        snd_if.req  = 1'b0;
        rcv_if.ack  = 1'b0;
        cfg_load    = 1'b0;
        xrst        = 1'b1;
        expq.delete();
        exp_out = 0;
        mpend   = 1'b0;
        for (int k = 0; k < NKNOT; k++) begin
            mkx[k] = (k + 1) * MAXV / (NKNOT + 1);
            mky[k] = (k + 1) * MAXV / (NKNOT + 1);
        end
        repeat (hold) @(negedge clk);
        chk("reset_rcv_req", longint'(rcv_if.req), 0);
        chk("reset_snd_ack", longint'(snd_if.ack), 0);
        chk("reset_pixel_out", longint'(snd_if.pixel), 0);
        xrst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
    endtask

    task automatic load(input logic [NKNOT*WIDTH-1:0] xv, input logic [NKNOT*WIDTH-1:0] yv);
        knot_x   = xv;
        knot_y   = yv;
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        mpend    = 1'b1;
    endtask

    task automatic load_random();
        int xs[NKNOT];
        int ys[NKNOT];
        int t;
        logic [NKNOT*WIDTH-1:0] xv;
        logic [NKNOT*WIDTH-1:0] yv;
        for (int k = 0; k < NKNOT; k++) begin
            xs[k] = int'($urandom_range(0, MAXV));
            ys[k] = int'($urandom_range(0, MAXV));
        end
        if ($urandom_range(0, 3) != 0) begin
            for (int i = 0; i < NKNOT; i++) begin
                for (int j = 0; j < NKNOT - 1 - i; j++) begin
                    if (xs[j] > xs[j+1]) begin t = xs[j]; xs[j] = xs[j+1]; xs[j+1] = t; end
                    if (ys[j] > ys[j+1]) begin t = ys[j]; ys[j] = ys[j+1]; ys[j+1] = t; end
                end
            end
        end
        for (int k = 0; k < NKNOT; k++) begin
            xv[k*WIDTH +: WIDTH] = WIDTH'(xs[k]);
            yv[k*WIDTH +: WIDTH] = WIDTH'(ys[k]);
        end
        load(xv, yv);
    endtask

    // One pixel transaction; lit >= 0 pins the model to a hand-computed value.
    task automatic pixel(input int v, input int lit, input int dly, input bit wait_done);
        int m;
        int k;
        @(negedge clk);
        if (mpend) begin
            for (int i = 0; i < NKNOT; i++) begin
                mkx[i] = int'(knot_x[i*WIDTH +: WIDTH]);
                mky[i] = int'(knot_y[i*WIDTH +: WIDTH]);
            end
            mpend = 1'b0;
        end
        m = model_map(v);
        if (lit >= 0) chk("model_pin", m, lit);
        snd_if.req = 1'b1;
        @(negedge clk);
        k = 0;
        while (rcv_if.req !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("rcv_req_rise_delay", k, 0);
        if (rcv_if.req !== 1'b1) begin
            snd_if.req = 1'b0;
            return;
        end
        snd_if.req = 1'b0;
        repeat (dly) begin
            @(negedge clk);
            chk("rcv_req_hold", longint'(rcv_if.req), 1);
        end
        rcv_if.ack   = 1'b1;
        rcv_if.pixel = WIDTH'(v);
        expq.push_back(exp_t'{cyc + LAT, (lit >= 0) ? lit : m});
        @(negedge clk);
        rcv_if.ack   = 1'b0;
        rcv_if.pixel = WIDTH'($urandom);
        chk("rcv_req_fall", longint'(rcv_if.req), 0);
        if (wait_done) repeat (LAT + 1) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int v;
        int kk;
        int w;
        snd_if.req   = 1'b0;
        rcv_if.ack   = 1'b0;
        rcv_if.pixel = '0;
        cfg_load     = 1'b0;
        knot_x       = '0;
        knot_y       = '0;
        xrst         = 1'b1;
        do_reset(2);

        // Identity defaults.
        pixel(0, 0, 0, 1);
        pixel(1, 1, 0, 1);
        pixel(85, 85, 0, 1);
        pixel(200, 200, 0, 1);
        pixel(255, 255, 0, 1);

        // S-curve knots.
        load({8'd192, 8'd64}, {8'd224, 8'd32});
        pixel(64, 32, 0, 1);
        pixel(100, 86, 0, 1);
        pixel(128, 128, 0, 1);
        pixel(200, 227, 0, 1);
        pixel(255, 255, 0, 1);

        // Slow upstream acknowledge.
        pixel(100, 86, 5, 1);

        // Load arriving mid-divide applies to the following pixel only.
        pixel(128, 128, 0, 0);
        repeat (6) @(negedge clk);
        load({8'd100, 8'd100}, {8'd60, 8'd50});
        repeat (LAT - 6) @(negedge clk);
        pixel(100, 50, 1, 1);
        pixel(150, 122, 0, 1);

        // Knot at x=0 gives a vertical first segment.
        load({8'd255, 8'd0}, {8'd200, 8'd40});
        pixel(0, 40, 0, 1);
        pixel(128, 120, 0, 1);
        pixel(255, 200, 0, 1);

        // Decreasing y is treated as misconfigured.
        load({8'd200, 8'd100}, {8'd50, 8'd150});
        pixel(150, 150, 0, 1);
        pixel(50, 75, 0, 1);

        // Reset in the middle of a divide.
        pixel(50, 75, 0, 0);
        repeat (5) @(negedge clk);
        do_reset(1);
        repeat (20) @(negedge clk);
        pixel(130, 130, 0, 1);
        pixel(37, 37, 2, 1);

        // Randomized pixels, knots and mid-pixel loads.
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 7) == 0) load_random();
            case ($urandom_range(0, 3))
                0, 1: v = int'($urandom_range(0, MAXV));
                2: v = ($urandom_range(0, 1) != 0) ? 0 : MAXV;
                default: begin
                    kk = int'($urandom_range(0, NKNOT - 1));
                    v  = int'(knot_x[kk*WIDTH +: WIDTH]) + int'($urandom_range(0, 2)) - 1;
                    if (v < 0) v = 0;
                    if (v > MAXV) v = MAXV;
                end
            endcase
            if ($urandom_range(0, 3) == 0) begin
                pixel(v, -1, int'($urandom_range(0, 3)), 0);
                w = int'($urandom_range(1, LAT - 1));
                repeat (w) @(negedge clk);
                load_random();
                repeat (LAT - w) @(negedge clk);
            end else begin
                pixel(v, -1, int'($urandom_range(0, 3)), 1);
            end
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
